// File: rtl/ysyx_23060236_rd_arbiter_pkg.sv
// Shared definitions for the read-channel arbiter.
//   - rd_state_e : arbiter FSM encodings (RD_IDLE, RD_AR, RD_R, RD_DRAIN)
//   - AXI response / burst constants
//   - default transaction IDs and the grant encoding used for last_grant
package ysyx_23060236_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_AR    = 2'd1,
        RD_R     = 2'd2,
        RD_DRAIN = 2'd3
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    localparam logic [3:0] DEFAULT_ID_IFU = 4'd0;
    localparam logic [3:0] DEFAULT_ID_LSU = 4'd1;

    // Encoding of the requester that owns (or last owned) the master port.
    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060236_rd_watchdog.sv
// Idle-cycle watchdog for the read arbiter.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-low reset
//   clear  : restart the count from zero (has priority over enable)
//   enable : count one cycle; the count saturates at TIMEOUT
//   fire   : high while enabled and the count has reached TIMEOUT
module ysyx_23060236_rd_watchdog #(
    parameter logic [9:0] TIMEOUT = 10'd1023
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fire
);

    logic [9:0] count;

    assign fire = enable && (count == TIMEOUT);

    // Saturating so fire stays asserted until the owner clears it, e.g.
    // while a requester is slow to accept the synthetic error beat.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= 10'd0;
        end else if (clear) begin
            count <= 10'd0;
        end else if (enable && (count != TIMEOUT)) begin
            count <= count + 10'd1;
        end
    end

endmodule

// File: rtl/ysyx_23060236_rd_arbiter.sv
// Read-channel arbiter: shares one AXI4 read master between the IFU (icache
// refill bursts) and the LSU (single-beat loads). Round-robin grant held for
// the whole transaction; a watchdog completes stalled reads with SLVERR.
// Ports:
//   clock, reset          : clock, synchronous active-low reset
//   ifu_ar* / ifu_r*      : IFU read address / data channels
//   lsu_ar* / lsu_r*      : LSU read address / data channels
//   mst_ar* / mst_r*      : shared master read address / data channels
//   debug_state           : current FSM state (rd_state_e encoding)
//   debug_beat_cnt        : beats accepted in the current/last transaction
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; valid, once raised, holds its payload
// stable until that edge, and ready may depend combinationally on valid.
module ysyx_23060236_rd_arbiter
    import ysyx_23060236_rd_arbiter_pkg::*;
#(
    parameter logic [9:0] TIMEOUT = 10'd1023,
    parameter logic [3:0] ID_IFU  = DEFAULT_ID_IFU,
    parameter logic [3:0] ID_LSU  = DEFAULT_ID_LSU
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [31:0] ifu_araddr,
    input  logic [3:0]  ifu_arlen,
    input  logic [1:0]  ifu_arburst,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rlast,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [31:0] lsu_araddr,
    input  logic [2:0]  lsu_arsize,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        mst_arvalid,
    input  logic        mst_arready,
    output logic [31:0] mst_araddr,
    output logic [3:0]  mst_arid,
    output logic [7:0]  mst_arlen,
    output logic [2:0]  mst_arsize,
    output logic [1:0]  mst_arburst,
    input  logic        mst_rvalid,
    output logic        mst_rready,
    input  logic [31:0] mst_rdata,
    input  logic [1:0]  mst_rresp,
    input  logic        mst_rlast,
    input  logic [3:0]  mst_rid,
    output logic [1:0]  debug_state,
    output logic [7:0]  debug_beat_cnt
);

    rd_state_e   state, state_next;
    logic        last_grant;
    logic        grant_lsu;
    logic [31:0] lat_addr;
    logic [7:0]  lat_len;
    logic [2:0]  lat_size;
    logic [1:0]  lat_burst;
    logic [3:0]  lat_id;
    logic [7:0]  beat_cnt;

    logic pick_lsu;
    logic take_ar;
    logic beat_ok;
    logic txn_done;
    logic wd_clear;
    logic wd_enable;
    logic wd_fire;

    // On a tie the requester that did not own the last transaction wins.
    assign pick_lsu = lsu_arvalid && (!ifu_arvalid || (last_grant == GRANT_IFU));

    assign mst_araddr     = lat_addr;
    assign mst_arid       = lat_id;
    assign mst_arlen      = lat_len;
    assign mst_arsize     = lat_size;
    assign mst_arburst    = lat_burst;
    assign debug_state    = state;
    assign debug_beat_cnt = beat_cnt;

    ysyx_23060236_rd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .fire   (wd_fire)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        take_ar     = 1'b0;
        beat_ok     = 1'b0;
        txn_done    = 1'b0;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = 32'd0;
        ifu_rresp   = RESP_OKAY;
        ifu_rlast   = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = 32'd0;
        lsu_rresp   = RESP_OKAY;
        mst_arvalid = 1'b0;
        mst_rready  = 1'b0;

        case (state)
            RD_IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    take_ar     = 1'b1;
                    ifu_arready = !pick_lsu;
                    lsu_arready = pick_lsu;
                    state_next  = RD_AR;
                end
            end
            RD_AR: begin
                mst_arvalid = 1'b1;
                // Holding the counter at zero here makes R start fresh.
                wd_clear = 1'b1;
                if (mst_arready) begin
                    state_next = RD_R;
                end
            end
            RD_R: begin
                wd_enable = 1'b1;
                if (wd_fire) begin
                    // Synthetic error beat; the master is not drained here.
                    if (grant_lsu) begin
                        lsu_rvalid = 1'b1;
                        lsu_rresp  = RESP_SLVERR;
                        if (lsu_rready) begin
                            state_next = RD_DRAIN;
                            wd_clear   = 1'b1;
                        end
                    end else begin
                        ifu_rvalid = 1'b1;
                        ifu_rresp  = RESP_SLVERR;
                        ifu_rlast  = 1'b1;
                        if (ifu_rready) begin
                            state_next = RD_DRAIN;
                            wd_clear   = 1'b1;
                        end
                    end
                end else begin
                    if (grant_lsu) begin
                        mst_rready = lsu_rready;
                        lsu_rvalid = mst_rvalid;
                        lsu_rdata  = mst_rdata;
                        lsu_rresp  = mst_rresp;
                    end else begin
                        mst_rready = ifu_rready;
                        ifu_rvalid = mst_rvalid;
                        ifu_rdata  = mst_rdata;
                        ifu_rresp  = mst_rresp;
                        ifu_rlast  = mst_rlast;
                    end
                    beat_ok = mst_rvalid && mst_rready;
                    if (beat_ok) begin
                        wd_clear = 1'b1;
                        if (mst_rlast) begin
                            state_next = RD_IDLE;
                            txn_done   = 1'b1;
                        end
                    end
                end
            end
            RD_DRAIN: begin
                wd_enable  = 1'b1;
                mst_rready = 1'b1;
                if (mst_rvalid) begin
                    wd_clear = 1'b1;
                end
                if ((mst_rvalid && mst_rlast) || wd_fire) begin
                    state_next = RD_IDLE;
                    txn_done   = 1'b1;
                end
            end
            default: begin
                state_next = RD_IDLE;
            end
        endcase

        // Outputs are forced quiet while reset is held so a requester that
        // keeps arvalid high through reset never sees a spurious arready.
        if (!reset) begin
            ifu_arready = 1'b0;
            lsu_arready = 1'b0;
            ifu_rvalid  = 1'b0;
            ifu_rdata   = 32'd0;
            ifu_rresp   = RESP_OKAY;
            ifu_rlast   = 1'b0;
            lsu_rvalid  = 1'b0;
            lsu_rdata   = 32'd0;
            lsu_rresp   = RESP_OKAY;
            mst_arvalid = 1'b0;
            mst_rready  = 1'b0;
            take_ar     = 1'b0;
            beat_ok     = 1'b0;
            txn_done    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant <= GRANT_IFU;
            grant_lsu  <= GRANT_IFU;
            lat_addr   <= 32'd0;
            lat_len    <= 8'd0;
            lat_size   <= 3'd0;
            lat_burst  <= 2'd0;
            lat_id     <= 4'd0;
            beat_cnt   <= 8'd0;
        end else begin
            if (take_ar) begin
                grant_lsu <= pick_lsu;
                beat_cnt  <= 8'd0;
                if (pick_lsu) begin
                    lat_addr  <= lsu_araddr;
                    lat_len   <= 8'd0;
                    lat_size  <= lsu_arsize;
                    lat_burst <= BURST_INCR;
                    lat_id    <= ID_LSU;
                end else begin
                    lat_addr  <= ifu_araddr;
                    lat_len   <= {4'b0, ifu_arlen};
                    lat_size  <= SIZE_WORD;
                    lat_burst <= ifu_arburst;
                    lat_id    <= ID_IFU;
                end
            end
            if (beat_ok) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
            if (txn_done) begin
                last_grant <= grant_lsu;
            end
        end
    end

    // Routing is by grant, not by rid; a mismatching rid means the slave
    // answered a transaction this arbiter never issued.
    always_ff @(posedge clock) begin
        if (reset && beat_ok) begin
            assert (mst_rid == lat_id);
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_rd_arbiter.sv
// Directed bench for ysyx_23060236_rd_arbiter (TIMEOUT overridden to 16).
module tb_ysyx_23060236_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_arvalid, ifu_arready;
    logic [31:0] ifu_araddr;
    logic [3:0]  ifu_arlen;
    logic [1:0]  ifu_arburst;
    logic        ifu_rvalid, ifu_rready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rlast;
    logic        lsu_arvalid, lsu_arready;
    logic [31:0] lsu_araddr;
    logic [2:0]  lsu_arsize;
    logic        lsu_rvalid, lsu_rready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        mst_arvalid, mst_arready;
    logic [31:0] mst_araddr;
    logic [3:0]  mst_arid;
    logic [7:0]  mst_arlen;
    logic [2:0]  mst_arsize;
    logic [1:0]  mst_arburst;
    logic        mst_rvalid, mst_rready;
    logic [31:0] mst_rdata;
    logic [1:0]  mst_rresp;
    logic        mst_rlast;
    logic [3:0]  mst_rid;
    logic [1:0]  debug_state;
    logic [7:0]  debug_beat_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int b;
    logic rdy_pat [7];
    logic exp_lsu;

    always #5 clock = ~clock;

    ysyx_23060236_rd_arbiter #(
        .TIMEOUT (10'd16),
        .ID_IFU  (4'd0),
        .ID_LSU  (4'd1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ifu_arvalid    (ifu_arvalid),
        .ifu_arready    (ifu_arready),
        .ifu_araddr     (ifu_araddr),
        .ifu_arlen      (ifu_arlen),
        .ifu_arburst    (ifu_arburst),
        .ifu_rvalid     (ifu_rvalid),
        .ifu_rready     (ifu_rready),
        .ifu_rdata      (ifu_rdata),
        .ifu_rresp      (ifu_rresp),
        .ifu_rlast      (ifu_rlast),
        .lsu_arvalid    (lsu_arvalid),
        .lsu_arready    (lsu_arready),
        .lsu_araddr     (lsu_araddr),
        .lsu_arsize     (lsu_arsize),
        .lsu_rvalid     (lsu_rvalid),
        .lsu_rready     (lsu_rready),
        .lsu_rdata      (lsu_rdata),
        .lsu_rresp      (lsu_rresp),
        .mst_arvalid    (mst_arvalid),
        .mst_arready    (mst_arready),
        .mst_araddr     (mst_araddr),
        .mst_arid       (mst_arid),
        .mst_arlen      (mst_arlen),
        .mst_arsize     (mst_arsize),
        .mst_arburst    (mst_arburst),
        .mst_rvalid     (mst_rvalid),
        .mst_rready     (mst_rready),
        .mst_rdata      (mst_rdata),
        .mst_rresp      (mst_rresp),
        .mst_rlast      (mst_rlast),
        .mst_rid        (mst_rid),
        .debug_state    (debug_state),
        .debug_beat_cnt (debug_beat_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One single-beat R transfer with rlast, accepted by the given requester.
    task automatic single_beat(input logic [3:0] id, input logic [31:0] data);
        mst_rvalid = 1'b1;
        mst_rdata  = data;
        mst_rresp  = 2'b00;
        mst_rlast  = 1'b1;
        mst_rid    = id;
        ifu_rready = 1'b1;
        lsu_rready = 1'b1;
        tick();
        mst_rvalid = 1'b0;
        mst_rlast  = 1'b0;
        ifu_rready = 1'b0;
        lsu_rready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        ifu_arvalid = 1'b0; ifu_araddr = 32'd0; ifu_arlen = 4'd0; ifu_arburst = 2'b01;
        ifu_rready = 1'b0;
        lsu_arvalid = 1'b0; lsu_araddr = 32'd0; lsu_arsize = 3'd0; lsu_rready = 1'b0;
        mst_arready = 1'b0; mst_rvalid = 1'b0; mst_rdata = 32'd0; mst_rresp = 2'b00;
        mst_rlast = 1'b0; mst_rid = 4'd0;
        tick();
        tick();

        // ---- reset state, with a request already pending
        ifu_arvalid = 1'b1;
        #1;
        chk("rst_ifu_arready", 32'(ifu_arready), 32'd0);
        chk("rst_mst_arvalid", 32'(mst_arvalid), 32'd0);
        chk("rst_state", 32'(debug_state), 32'd0);
        chk("rst_araddr", mst_araddr, 32'd0);
        ifu_arvalid = 1'b0;
        reset = 1'b1;
        tick();

        // ---- IFU only, 4-beat burst
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0000; ifu_arlen = 4'd3; ifu_arburst = 2'b01;
        #1;
        chk("t1_ifu_arready", 32'(ifu_arready), 32'd1);
        chk("t1_lsu_arready", 32'(lsu_arready), 32'd0);
        tick();
        ifu_arvalid = 1'b0;
        mst_arready = 1'b1;
        #1;
        chk("t1_arvalid", 32'(mst_arvalid), 32'd1);
        chk("t1_araddr", mst_araddr, 32'h3000_0000);
        chk("t1_arid", 32'(mst_arid), 32'd0);
        chk("t1_arlen", 32'(mst_arlen), 32'd3);
        chk("t1_arsize", 32'(mst_arsize), 32'd2);
        chk("t1_arburst", 32'(mst_arburst), 32'd1);
        tick();
        mst_arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mst_rvalid = 1'b1; mst_rdata = 32'hA0 + 32'(i); mst_rlast = (i == 3);
            mst_rid = 4'd0; ifu_rready = 1'b1;
            #1;
            chk("t1_ifu_rvalid", 32'(ifu_rvalid), 32'd1);
            chk("t1_ifu_rdata", ifu_rdata, 32'hA0 + 32'(i));
            chk("t1_ifu_rlast", 32'(ifu_rlast), (i == 3) ? 32'd1 : 32'd0);
            chk("t1_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
            chk("t1_mst_rready", 32'(mst_rready), 32'd1);
            tick();
        end
        mst_rvalid = 1'b0; mst_rlast = 1'b0; ifu_rready = 1'b0;
        #1;
        chk("t1_back_idle", 32'(debug_state), 32'd0);

        // ---- simultaneous requests right after reset: LSU first
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0100; ifu_arlen = 4'd0;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0010; lsu_arsize = 3'd2;
        #1;
        chk("t2_lsu_arready", 32'(lsu_arready), 32'd1);
        chk("t2_ifu_arready", 32'(ifu_arready), 32'd0);
        tick();
        lsu_arvalid = 1'b0;
        #1;
        chk("t2_arid", 32'(mst_arid), 32'd1);
        chk("t2_araddr", mst_araddr, 32'h0F00_0010);
        chk("t2_arlen", 32'(mst_arlen), 32'd0);
        chk("t2_arsize", 32'(mst_arsize), 32'd2);
        chk("t2_arburst", 32'(mst_arburst), 32'd1);
        chk("t2_ifu_wait_ar", 32'(ifu_arready), 32'd0);
        mst_arready = 1'b1;
        tick();
        mst_arready = 1'b0;
        mst_rvalid = 1'b1; mst_rdata = 32'hDEAD_BEEF; mst_rlast = 1'b1; mst_rid = 4'd1;
        lsu_rready = 1'b1;
        #1;
        chk("t2_lsu_rvalid", 32'(lsu_rvalid), 32'd1);
        chk("t2_lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
        chk("t2_lsu_rresp", 32'(lsu_rresp), 32'd0);
        chk("t2_ifu_rvalid", 32'(ifu_rvalid), 32'd0);
        chk("t2_ifu_wait_r", 32'(ifu_arready), 32'd0);
        tick();
        mst_rvalid = 1'b0; mst_rlast = 1'b0; lsu_rready = 1'b0;
        #1;
        chk("t2_ifu_arready", 32'(ifu_arready), 32'd1);
        tick();
        ifu_arvalid = 1'b0;
        #1;
        chk("t2_ifu_arid", 32'(mst_arid), 32'd0);
        mst_arready = 1'b1;
        tick();
        mst_arready = 1'b0;
        single_beat(4'd0, 32'h1111_2222);

        // ---- alternating pressure: last owner was IFU, so LSU leads
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp_lsu = ((t % 2) == 0);
            #1;
            chk("t3_lsu_arready", 32'(lsu_arready), 32'(exp_lsu));
            chk("t3_ifu_arready", 32'(ifu_arready), 32'(!exp_lsu));
            tick();
            chk("t3_arid", 32'(mst_arid), exp_lsu ? 32'd1 : 32'd0);
            mst_arready = 1'b1;
            tick();
            mst_arready = 1'b0;
            single_beat(exp_lsu ? 4'd1 : 4'd0, 32'h100 + 32'(t));
        end
        ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;

        // ---- backpressure on AR and R
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0040; ifu_arlen = 4'd3;
        tick();
        ifu_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_arvalid_held", 32'(mst_arvalid), 32'd1);
            chk("t4_araddr_held", mst_araddr, 32'h3000_0040);
            chk("t4_arlen_held", 32'(mst_arlen), 32'd3);
            tick();
        end
        mst_arready = 1'b1;
        tick();
        mst_arready = 1'b0;
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        b = 0;
        for (int c = 0; c < 7; c++) begin
            mst_rvalid = 1'b1; mst_rdata = 32'hB0 + 32'(b); mst_rlast = (b == 3);
            mst_rid = 4'd0; ifu_rready = rdy_pat[c];
            #1;
            chk("t4_mst_rready", 32'(mst_rready), 32'(rdy_pat[c]));
            chk("t4_ifu_rdata", ifu_rdata, 32'hB0 + 32'(b));
            chk("t4_ifu_rlast", 32'(ifu_rlast), (b == 3) ? 32'd1 : 32'd0);
            tick();
            if (rdy_pat[c]) b++;
        end
        mst_rvalid = 1'b0; mst_rlast = 1'b0; ifu_rready = 1'b0;
        #1;
        chk("t4_state_idle", 32'(debug_state), 32'd0);
        chk("t4_beat_cnt", 32'(debug_beat_cnt), 32'd4);

        // ---- watchdog on an LSU read that never answers
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0020; lsu_arsize = 3'd2;
        tick();
        lsu_arvalid = 1'b0;
        mst_arready = 1'b1;
        tick();
        mst_arready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("t5_quiet", 32'(lsu_rvalid), 32'd0);
            tick();
        end
        chk("t5_fire_rvalid", 32'(lsu_rvalid), 32'd1);
        chk("t5_fire_rresp", 32'(lsu_rresp), 32'd2);
        chk("t5_fire_rdata", lsu_rdata, 32'd0);
        chk("t5_fire_mst_rready", 32'(mst_rready), 32'd0);
        tick();
        chk("t5_fire_held", 32'(lsu_rvalid), 32'd1);
        lsu_rready = 1'b1;
        tick();
        lsu_rready = 1'b0;
        #1;
        chk("t5_drain_state", 32'(debug_state), 32'd3);
        chk("t5_drain_rready", 32'(mst_rready), 32'd1);
        mst_rvalid = 1'b1; mst_rdata = 32'h55; mst_rlast = 1'b1; mst_rid = 4'd1;
        #1;
        chk("t5_drain_no_rvalid", 32'(lsu_rvalid), 32'd0);
        tick();
        mst_rvalid = 1'b0; mst_rlast = 1'b0;
        #1;
        chk("t5_after_drain", 32'(debug_state), 32'd0);
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0200; ifu_arlen = 4'd0;
        #1;
        chk("t5_next_grant", 32'(ifu_arready), 32'd1);
        tick();
        ifu_arvalid = 1'b0;
        mst_arready = 1'b1;
        tick();
        mst_arready = 1'b0;
        single_beat(4'd0, 32'h7777_0000);

        // ---- reset in the middle of an IFU burst
        ifu_arvalid = 1'b1; ifu_araddr = 32'h3000_0300; ifu_arlen = 4'd3;
        tick();
        ifu_arvalid = 1'b0;
        mst_arready = 1'b1;
        tick();
        mst_arready = 1'b0;
        mst_rvalid = 1'b1; mst_rdata = 32'hC0; mst_rlast = 1'b0; mst_rid = 4'd0; ifu_rready = 1'b1;
        tick();
        mst_rdata = 32'hC1;
        reset = 1'b0;
        tick();
        chk("t6_rst_state", 32'(debug_state), 32'd0);
        chk("t6_rst_ifu_rvalid", 32'(ifu_rvalid), 32'd0);
        chk("t6_rst_ifu_rdata", ifu_rdata, 32'd0);
        chk("t6_rst_mst_rready", 32'(mst_rready), 32'd0);
        chk("t6_rst_arvalid", 32'(mst_arvalid), 32'd0);
        chk("t6_rst_arid", 32'(mst_arid), 32'd0);
        mst_rvalid = 1'b0; ifu_rready = 1'b0;
        reset = 1'b1;
        tick();
        lsu_arvalid = 1'b1; lsu_araddr = 32'h0F00_0030; lsu_arsize = 3'd2;
        #1;
        chk("t6_lsu_arready", 32'(lsu_arready), 32'd1);
        tick();
        lsu_arvalid = 1'b0;
        #1;
        chk("t6_lsu_arid", 32'(mst_arid), 32'd1);
        chk("t6_lsu_araddr", mst_araddr, 32'h0F00_0030);
        mst_arready = 1'b1;
        tick();
        mst_arready = 1'b0;
        mst_rvalid = 1'b1; mst_rdata = 32'h0BAD_F00D; mst_rlast = 1'b1; mst_rid = 4'd1;
        lsu_rready = 1'b1;
        #1;
        chk("t6_lsu_rdata", lsu_rdata, 32'h0BAD_F00D);
        tick();
        mst_rvalid = 1'b0; mst_rlast = 1'b0; lsu_rready = 1'b0;
        #1;
        chk("t6_final_idle", 32'(debug_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
